// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM handshake state and the arbiter grant state.
// Also provides the arbitration priority function used by mem_arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    // On a tie the client that did not own the previous grant wins.
    function automatic arb_state_t arbitrate(input logic ireq, input logic dreq, input logic last_d);
        arb_state_t result;
        result = ARB_IDLE;
        if (ireq && dreq) begin
            result = last_d ? ARB_I : ARB_D;
        end else if (dreq) begin
            result = ARB_D;
        end else if (ireq) begin
            result = ARB_I;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter_perf.sv
// Wrapping performance counter bank for the memory arbiter.
// Only compiled in when MEMARB_PERF_EN is defined.
`ifdef MEMARB_PERF_EN
module mem_arbiter_perf #(
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_done,
    input  logic              d_done,
    input  logic              stall,
    input  logic              err,
    output logic [PERF_W-1:0] icnt,
    output logic [PERF_W-1:0] dcnt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] err_cnt
);

    localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [3:0]        inc;
    logic [PERF_W-1:0] cnt_reg [4];

    assign inc = {err, stall, d_done, i_done};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + ONE;
                end
            end
        end
    endgenerate

    assign icnt      = cnt_reg[0];
    assign dcnt      = cnt_reg[1];
    assign stall_cnt = cnt_reg[2];
    assign err_cnt   = cnt_reg[3];

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter onto a single RAM port with sticky grants for dcache bursts.
// Define MEMARB_PERF_EN to add the icnt/dcnt/stall_cnt/err_cnt counter ports.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEMARB_PERF_EN
    ,
    output logic [PERF_W-1:0] icnt,
    output logic [PERF_W-1:0] dcnt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] err_cnt
`endif
);

    arb_state_t state_reg, state_next;
    logic       last_d_reg, last_d_next;
    logic       dreq;
    ramstate_t  rs;

    assign dreq  = dREN | dWEN;
    assign rs    = ramstate_t'(ramstate);
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg  <= ARB_IDLE;
            last_d_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
        end
    end

    // The owner keeps the grant while requesting; once it lets go we re-arbitrate
    // immediately so a handoff to the other cache costs no idle cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: state_next = arbitrate(iREN, dreq, last_d_reg);
            ARB_D:    state_next = dreq ? ARB_D : arbitrate(iREN, dreq, last_d_reg);
            ARB_I:    state_next = iREN ? ARB_I : arbitrate(iREN, dreq, last_d_reg);
            default:  state_next = ARB_IDLE;
        endcase
        last_d_next = last_d_reg;
        if (state_next == ARB_D) begin
            last_d_next = 1'b1;
        end else if (state_next == ARB_I) begin
            last_d_next = 1'b0;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_reg)
            ARB_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~(dreq && (rs == ACCESS));
            end
            ARB_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~(iREN && (rs == ACCESS));
            end
            default: ;
        endcase
    end

`ifdef MEMARB_PERF_EN
    logic i_done, d_done, stall, err;

    assign i_done = (state_reg == ARB_I) && !iwait;
    assign d_done = (state_reg == ARB_D) && !dwait;
    assign stall  = ((state_reg == ARB_I) && dreq) || ((state_reg == ARB_D) && iREN);
    assign err    = (state_reg != ARB_IDLE) && (rs == ERROR);

    mem_arbiter_perf #(
        .PERF_W (PERF_W)
    ) u_perf (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_done    (i_done),
        .d_done    (d_done),
        .stall     (stall),
        .err       (err),
        .icnt      (icnt),
        .dcnt      (dcnt),
        .stall_cnt (stall_cnt),
        .err_cnt   (err_cnt)
    );
`else
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; counter checks are active
// when MEMARB_PERF_EN is defined.
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef MEMARB_PERF_EN
    logic [31:0] icnt, dcnt, stall_cnt, err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.PERF_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEMARB_PERF_EN
        ,
        .icnt      (icnt),
        .dcnt      (dcnt),
        .stall_cnt (stall_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
        tick();
        tick();
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN: got %b expected 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN: got %b expected 0", ramWEN); end
        checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("FAIL reset_waits: got %b expected 11", {iwait, dwait}); end
        nRST = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_arb_cycle: ramREN got %b expected 0", ramREN); end
        tick();
        #1;
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL reset_first_grant: got REN=%b addr=%h expected REN=1 addr=00000040", ramREN, ramaddr); end
        $display("test_reset done");
    endtask

    task automatic test_icache();
        do_reset();
        iREN = 1'b1; iaddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = RS_BUSY;
        #1;
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL icache_idle: got REN,iwait=%b expected 01", {ramREN, iwait}); end
        tick(); #1;
        checks++; if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h100, 1'b1}) begin errors++; $display("FAIL icache_busy1: got REN=%b addr=%h iwait=%b", ramREN, ramaddr, iwait); end
        tick(); #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL icache_busy2: iwait got %b expected 1", iwait); end
        tick(); ramstate = RS_ACCESS; #1;
        checks++; if ({iwait, dwait} !== 2'b01) begin errors++; $display("FAIL icache_access: iwait,dwait got %b expected 01", {iwait, dwait}); end
        checks++; if (iload !== 32'hDEADBEEF) begin errors++; $display("FAIL icache_iload: got %h expected deadbeef", iload); end
        tick(); iREN = 1'b0; ramstate = RS_FREE; #1;
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL icache_release: REN,iwait got %b expected 01", {ramREN, iwait}); end
        $display("test_icache done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h11111111;
        iREN = 1'b1; iaddr = 32'h300; ramstate = RS_FREE;
        #1;
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wb_idle: ramWEN got %b expected 0", ramWEN); end
        tick(); ramstate = RS_ACCESS; #1;
        checks++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'h11111111}) begin errors++; $display("FAIL wb_word0: got WEN=%b REN=%b addr=%h data=%h", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if ({dwait, iwait} !== 2'b01) begin errors++; $display("FAIL wb_word0_waits: dwait,iwait got %b expected 01", {dwait, iwait}); end
        tick(); daddr = 32'h204; dstore = 32'h22222222; #1;
        checks++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h204, 32'h22222222}) begin errors++; $display("FAIL wb_word1: got WEN=%b REN=%b addr=%h data=%h", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if ({dwait, iwait} !== 2'b01) begin errors++; $display("FAIL wb_word1_waits: dwait,iwait got %b expected 01", {dwait, iwait}); end
        tick(); dWEN = 1'b0; ramstate = RS_FREE; #1;
        checks++; if ({ramWEN, ramREN, dwait, iwait} !== 4'b0011) begin errors++; $display("FAIL wb_release: WEN,REN,dwait,iwait got %b expected 0011", {ramWEN, ramREN, dwait, iwait}); end
        tick(); #1;
        checks++; if ({ramREN, ramWEN, ramaddr, iwait} !== {2'b10, 32'h300, 1'b1}) begin errors++; $display("FAIL wb_handoff: got REN=%b WEN=%b addr=%h iwait=%b", ramREN, ramWEN, ramaddr, iwait); end
        $display("test_back_to_back done");
    endtask

    task automatic test_fairness();
        do_reset();
        iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h500; ramstate = RS_ACCESS;
        tick(); #1;
        checks++; if ({ramaddr, dwait, iwait} !== {32'h500, 2'b01}) begin errors++; $display("FAIL fair_d1: got addr=%h dwait=%b iwait=%b", ramaddr, dwait, iwait); end
        tick(); dREN = 1'b0; #1;
        checks++; if ({ramREN, dwait} !== 2'b01) begin errors++; $display("FAIL fair_d1_release: REN,dwait got %b expected 01", {ramREN, dwait}); end
        tick(); dREN = 1'b1; #1;
        checks++; if ({ramaddr, iwait, dwait} !== {32'h400, 2'b01}) begin errors++; $display("FAIL fair_i1: got addr=%h iwait=%b dwait=%b", ramaddr, iwait, dwait); end
        tick(); iREN = 1'b0; #1;
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL fair_i1_release: REN,iwait got %b expected 01", {ramREN, iwait}); end
        tick(); iREN = 1'b1; #1;
        checks++; if ({ramaddr, dwait, iwait} !== {32'h500, 2'b01}) begin errors++; $display("FAIL fair_d2: got addr=%h dwait=%b iwait=%b", ramaddr, dwait, iwait); end
        tick(); iREN = 1'b0; dREN = 1'b0; #1;
        tick(); iREN = 1'b1; dREN = 1'b1; #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fair_idle: ramREN got %b expected 0", ramREN); end
        tick(); #1;
        checks++; if ({ramaddr, iwait, dwait} !== {32'h400, 2'b01}) begin errors++; $display("FAIL fair_last_d_tie: got addr=%h iwait=%b dwait=%b", ramaddr, iwait, dwait); end
        $display("test_fairness done");
    endtask

    task automatic test_error_hold();
        do_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFEF00D; ramstate = RS_FREE;
        for (int k = 0; k < 3; k++) begin
            tick(); ramstate = RS_ERROR; #1;
            checks++; if ({ramWEN, ramREN, dwait, ramaddr} !== {3'b101, 32'h600}) begin errors++; $display("FAIL err_hold%0d: got WEN=%b REN=%b dwait=%b addr=%h", k, ramWEN, ramREN, dwait, ramaddr); end
        end
        tick(); ramstate = RS_ACCESS; #1;
        checks++; if ({ramWEN, ramREN, dwait, ramstore} !== {3'b100, 32'hCAFEF00D}) begin errors++; $display("FAIL err_recover: got WEN=%b REN=%b dwait=%b data=%h", ramWEN, ramREN, dwait, ramstore); end
        tick(); dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE; #1;
`ifdef MEMARB_PERF_EN
        checks++; if (err_cnt !== 32'd3) begin errors++; $display("FAIL err_cnt: got %0d expected 3", err_cnt); end
        checks++; if ({dcnt, stall_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL err_dcnt_stall: got dcnt=%0d stall=%0d expected 1 0", dcnt, stall_cnt); end
`endif
        $display("test_error_hold done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        dREN = 1'b1; daddr = 32'h700; ramload = 32'h12345678; ramstate = RS_FREE;
        tick(); ramstate = RS_ACCESS; #1;
        checks++; if ({dwait, dload} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL mid_word0: got dwait=%b dload=%h", dwait, dload); end
        tick(); daddr = 32'h704; ramstate = RS_BUSY; nRST = 1'b0; #1;
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h704}) begin errors++; $display("FAIL mid_before_edge: got REN=%b addr=%h", ramREN, ramaddr); end
        tick(); #1;
        checks++; if ({ramREN, ramWEN, dwait} !== 3'b001) begin errors++; $display("FAIL mid_reset: REN,WEN,dwait got %b expected 001", {ramREN, ramWEN, dwait}); end
`ifdef MEMARB_PERF_EN
        checks++; if ({icnt, dcnt, stall_cnt, err_cnt} !== 128'd0) begin errors++; $display("FAIL mid_counters: got %0d %0d %0d %0d expected zero", icnt, dcnt, stall_cnt, err_cnt); end
`endif
        nRST = 1'b1; dREN = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_icache();
        test_back_to_back();
        test_fairness();
        test_error_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
